// File: rtl/ws281x_pkg.sv
// Shared WS281X definitions: pixel word type, default bit/latch timing and
// the encoder state encoding. The splitter on the receive side reuses the
// same timing constants to place its sampling point.
package ws281x_pkg;

   localparam int PIXEL_BITS = 24;

   typedef logic [PIXEL_BITS-1:0] pixel_t;

   // Default timing at 50 MHz: 0.24us high, 0.38us data, 0.62us low, 50us latch
   localparam int T_HIGH       = 12;
   localparam int T_DATA       = 19;
   localparam int T_LOW        = 31;
   localparam int LATCH_CYCLES = 2500;

   // Encoder state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HIGH  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_LOW   = 3'd3;
   localparam logic [2:0] ST_LATCH = 3'd4;

   // Width of the shared phase counter; the latch is the longest phase, so
   // every bit phase no longer than the latch fits without truncation.
   function automatic int phase_width(input int latch_cycles);
      return (latch_cycles > 1) ? $clog2(latch_cycles) : 1;
   endfunction

endpackage

// File: rtl/ws281x_bit_timer.sv
// Phase sequencer for one WS281X bit (HIGH -> DATA -> LOW) plus the latch
// period. One counter is shared by all phases. The owner requests a new bit
// with 'start'; the request is honoured while idle, at the last LOW cycle
// (back-to-back bits) and at the last LATCH cycle (a queued pixel begins
// immediately after the latch without an idle cycle).
module ws281x_bit_timer #(
   parameter int T_HIGH       = ws281x_pkg::T_HIGH,
   parameter int T_DATA       = ws281x_pkg::T_DATA,
   parameter int T_LOW        = ws281x_pkg::T_LOW,
   parameter int LATCH_CYCLES = ws281x_pkg::LATCH_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       bit_value,
   output logic       dout,
   output logic       bit_end,
   output logic       latch_end,
   output logic [2:0] state
);
   import ws281x_pkg::*;

   localparam int CW = phase_width(LATCH_CYCLES);

   localparam logic [CW-1:0] HIGH_LAST  = CW'(T_HIGH - 1);
   localparam logic [CW-1:0] DATA_LAST  = CW'(T_DATA - 1);
   localparam logic [CW-1:0] LOW_LAST   = CW'(T_LOW - 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] phase_reg, phase_next;
   logic          dout_reg, dout_next;
   logic          phase_last;

   // Detect the final cycle of whichever phase is running
   always_comb begin
      phase_last = 1'b0;
      case (state_reg)
         ST_HIGH:  phase_last = (phase_reg == HIGH_LAST);
         ST_DATA:  phase_last = (phase_reg == DATA_LAST);
         ST_LOW:   phase_last = (phase_reg == LOW_LAST);
         ST_LATCH: phase_last = (phase_reg == LATCH_LAST);
         default:  phase_last = 1'b0;
      endcase
   end

   // Next phase/counter; Dout is derived from the state being entered so the
   // registered output lines up exactly with the state register
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg + CW'(1);
      case (state_reg)
         ST_IDLE: begin
            phase_next = '0;
            if (start) state_next = ST_HIGH;
         end
         ST_HIGH: begin
            if (phase_last) begin
               state_next = ST_DATA;
               phase_next = '0;
            end
         end
         ST_DATA: begin
            if (phase_last) begin
               state_next = ST_LOW;
               phase_next = '0;
            end
         end
         ST_LOW: begin
            if (phase_last) begin
               state_next = start ? ST_HIGH : ST_LATCH;
               phase_next = '0;
            end
         end
         ST_LATCH: begin
            if (phase_last) begin
               state_next = start ? ST_HIGH : ST_IDLE;
               phase_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            phase_next = '0;
         end
      endcase
      dout_next = (state_next == ST_HIGH) || ((state_next == ST_DATA) && bit_value);
   end

   // State, phase counter and line driver; reset forces the line low at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         phase_reg <= '0;
         dout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         dout_reg  <= dout_next;
      end
   end

   assign dout      = dout_reg;
   assign state     = state_reg;
   assign bit_end   = (state_reg == ST_LOW) && phase_last;
   assign latch_end = (state_reg == ST_LATCH) && phase_last;

endmodule

// File: rtl/ws281x_encoder.sv
// WS281X serialiser: a one-word holding register decouples the pixel source
// from the shift register so consecutive pixels go out without a gap. When
// the holding register is empty at the end of a pixel the line is held low
// for the latch period so the LED chain displays the frame.
module ws281x_encoder #(
   parameter int T_HIGH       = ws281x_pkg::T_HIGH,
   parameter int T_DATA       = ws281x_pkg::T_DATA,
   parameter int T_LOW        = ws281x_pkg::T_LOW,
   parameter int LATCH_CYCLES = ws281x_pkg::LATCH_CYCLES
) (
   input  logic                              Clock,
   input  logic                              Reset_n,
   input  logic [ws281x_pkg::PIXEL_BITS-1:0] PixelIn,
   input  logic                              PixelValid,
   output logic                              Ready,
   output logic                              Dout,
   output logic                              Busy,
   output logic                              Latching,
   output logic                              PixelDone
);
   import ws281x_pkg::*;

   localparam logic [4:0] BIT_FIRST = 5'(PIXEL_BITS - 1);

   pixel_t     hold_reg;
   logic       hold_full_reg;
   pixel_t     shift_reg;
   logic [4:0] bit_reg;
   logic       ready_en_reg;

   logic       accept;
   logic       start_ok;
   logic       load;
   logic       next_bit;
   logic       bit_end;
   logic       latch_end;
   logic [2:0] state;

   // Points where a fresh pixel may begin: idle, end of the latch, or the
   // last LOW cycle of bit 0. Underrun is judged on hold_full_reg before the
   // edge, so a word arriving on that very edge still waits out the latch.
   assign start_ok = (state == ST_IDLE) || latch_end || (bit_end && (bit_reg == 5'd0));
   assign load     = hold_full_reg && start_ok;
   assign next_bit = bit_end && (bit_reg != 5'd0);
   assign accept   = PixelValid && Ready;

   ws281x_bit_timer #(
      .T_HIGH       (T_HIGH),
      .T_DATA       (T_DATA),
      .T_LOW        (T_LOW),
      .LATCH_CYCLES (LATCH_CYCLES)
   ) u_bit_timer (
      .clk       (Clock),
      .rst_n     (Reset_n),
      .start     (load || next_bit),
      .bit_value (shift_reg[PIXEL_BITS-1]),
      .dout      (Dout),
      .bit_end   (bit_end),
      .latch_end (latch_end),
      .state     (state)
   );

   // Keep Ready low while reset is held and for no longer than that
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) ready_en_reg <= 1'b0;
      else          ready_en_reg <= 1'b1;
   end

   // Holding register: filled on handshake, emptied when moved to the shifter
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else if (accept) begin
         hold_reg      <= PixelIn;
         hold_full_reg <= 1'b1;
      end else if (load) begin
         hold_full_reg <= 1'b0;
      end
   end

   // Shift register and bit index; MSB is always the bit on the wire
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         shift_reg <= '0;
         bit_reg   <= 5'd0;
      end else if (load) begin
         shift_reg <= hold_reg;
         bit_reg   <= BIT_FIRST;
      end else if (next_bit) begin
         shift_reg <= {shift_reg[PIXEL_BITS-2:0], 1'b0};
         bit_reg   <= bit_reg - 5'd1;
      end
   end

   assign Ready     = ready_en_reg && !hold_full_reg;
   assign Busy      = (state != ST_IDLE);
   assign Latching  = (state == ST_LATCH);
   assign PixelDone = bit_end && (bit_reg == 5'd0);

endmodule
